// File: rtl/mp_sysbus_q_pkg.sv
// Shared tag/mask encodings, bus FSM states and command-formatting helpers
// for the queued system-bus management master.
package mp_sysbus_q_pkg;

  localparam logic [1:0] TAG_W = 2'b00;
  localparam logic [1:0] TAG_L = 2'b01;
  localparam logic [1:0] TAG_H = 2'b10;

  localparam logic [1:0] EVB_MASK_NONE = 2'b00;
  localparam logic [1:0] EVB_MASK_LO   = 2'b01;
  localparam logic [1:0] EVB_MASK_HI   = 2'b10;
  localparam logic [1:0] EVB_MASK_W    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } bus_state_e;

  // Per-half operand forwarding applied in the issue cycle.
  function automatic logic [31:0] fwd_mux(input logic [1:0] fwd_en,
                                          input logic [31:0] fwd_data,
                                          input logic [31:0] data);
    fwd_mux = {fwd_en[1] ? fwd_data[31:16] : data[31:16],
               fwd_en[0] ? fwd_data[15:0]  : data[15:0]};
  endfunction

  function automatic logic [31:0] pack_txd(input logic [1:0] tag,
                                           input logic sel,
                                           input logic [31:0] d32);
    logic [15:0] d16;
    d16 = sel ? d32[31:16] : d32[15:0];
    case (tag)
      TAG_H:   pack_txd = {d16, 16'h0000};
      TAG_L:   pack_txd = {16'h0000, d16};
      default: pack_txd = d32;
    endcase
  endfunction

  function automatic logic [1:0] wen_of(input logic rd, input logic [1:0] tag);
    if (rd) begin
      wen_of = EVB_MASK_NONE;
    end else begin
      case (tag)
        TAG_H:   wen_of = EVB_MASK_HI;
        TAG_L:   wen_of = EVB_MASK_LO;
        default: wen_of = EVB_MASK_W;
      endcase
    end
  endfunction

  // High-half reads are replicated into both halves; others pass through.
  function automatic logic [31:0] fmt_rd(input logic [1:0] tag, input logic [31:0] rxd);
    if (tag == TAG_H) fmt_rd = {rxd[31:16], rxd[31:16]};
    else              fmt_rd = rxd;
  endfunction

endpackage

// File: rtl/mp_sysbus_fifo.sv
// Synchronous in-order FIFO holding posted bus commands; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module mp_sysbus_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_setn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge sys_clk) begin
    if (sys_setn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mp_sysbus_q.sv
// Queued management-bus master: buffers EVB loads/stores in order and plays
// them out one at a time over the mgmt handshake with a per-transaction timeout.
module mp_sysbus_q
  import mp_sysbus_q_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_setn,
  input  logic              issue,
  input  logic              rd,
  input  logic [1:0]        tag2,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  input  logic [1:0]        fwd_en,
  input  logic [31:0]       fwd_data,
  output logic              stall,
  output logic              wb,
  output logic              wb32,
  output logic [31:0]       wb_data,
  output logic              err,
  output logic              mgmt_req,
  output logic [31:0]       mgmt_adr,
  output logic              mgmt_rwn,
  output logic [1:0]        mgmt_wen,
  output logic [31:0]       mgmt_txd,
  input  logic              mgmt_ack,
  input  logic              mgmt_rxe,
  input  logic [31:0]       mgmt_rxd
);

  localparam int ENT_W = 1 + 2 + ADDR_W + 32 + 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  bus_state_e        state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tmo_hit;

  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  push_entry;
  logic [ENT_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;

  logic              head_rd;
  logic [1:0]        head_tag;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_txd;
  logic [1:0]        head_wen;

  logic              stall_q, stall_d;
  logic              rd_pend_q, rd_pend_d;
  logic              wb_q, wb_d;
  logic              wb32_q, wb32_d;
  logic              err_q, err_d;
  logic              mgmt_req_q;
  logic [31:0]       wb_data_q, wb_data_d;

  // Stall normally keeps a full queue from being pushed; the full term only
  // matters if a push and pop ever line up in the same cycle.
  assign push       = issue && !stall_q && (!fifo_full || pop);
  assign push_entry = {rd, tag2, addr,
                       pack_txd(tag2, sel, fwd_mux(fwd_en, fwd_data, data)),
                       wen_of(rd, tag2)};

  mp_sysbus_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_setn  (sys_setn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_rd, head_tag, head_addr, head_txd, head_wen} = head;

  assign mgmt_adr = 32'(head_addr);
  assign mgmt_rwn = head_rd;
  assign mgmt_wen = head_wen;
  assign mgmt_txd = head_txd;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_setn) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    pop       = 1'b0;
    wb_d      = 1'b0;
    wb32_d    = 1'b0;
    err_d     = 1'b0;
    wb_data_d = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || push) begin
          state_d = ST_REQ;
          tmo_d   = '0;
        end
      end
      ST_REQ: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (mgmt_ack && (!head_rd || mgmt_rxe)) state_d = ST_DONE;
        else if (mgmt_ack)                      state_d = ST_WAIT;
        else if (tmo_hit)                       state_d = ST_ABORT;
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (mgmt_rxe)     state_d = ST_DONE;
        else if (tmo_hit) state_d = ST_ABORT;
      end
      ST_DONE, ST_ABORT: begin
        pop     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Writeback and error are raised on the edge that enters DONE/ABORT.
    if (state_d == ST_DONE && state_q != ST_DONE && head_rd) begin
      wb_d      = 1'b1;
      wb32_d    = (head_tag == TAG_W);
      wb_data_d = fmt_rd(head_tag, mgmt_rxd);
    end
    if (state_d == ST_ABORT && state_q != ST_ABORT) begin
      err_d = 1'b1;
      if (head_rd) begin
        wb_d      = 1'b1;
        wb32_d    = (head_tag == TAG_W);
        wb_data_d = '0;
      end
    end
  end

  // A read holds the core until its own writeback; writes only when full.
  always_comb begin
    rd_pend_d = rd_pend_q;
    if (push && rd) rd_pend_d = 1'b1;
    if (wb_d)       rd_pend_d = 1'b0;
  end

  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign stall_d    = rd_pend_d || (count_next == CNT_W'(DEPTH));

  always_ff @(posedge sys_clk) begin
    if (sys_setn) begin
      stall_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      wb_q       <= 1'b0;
      wb32_q     <= 1'b0;
      err_q      <= 1'b0;
      mgmt_req_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      stall_q    <= stall_d;
      rd_pend_q  <= rd_pend_d;
      wb_q       <= wb_d;
      wb32_q     <= wb32_d;
      err_q      <= err_d;
      mgmt_req_q <= (state_d == ST_REQ);
      wb_data_q  <= wb_data_d;
    end
  end

  assign stall    = stall_q;
  assign wb       = wb_q;
  assign wb32     = wb32_q;
  assign err      = err_q;
  assign mgmt_req = mgmt_req_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_mp_sysbus_q.sv
// Directed bench for mp_sysbus_q: a vector table of single zero-wait ops plus
// hand-written sequences for full stall, timeout, ordering and reset.
module tb_mp_sysbus_q;
  import mp_sysbus_q_pkg::*;

  logic        sys_clk;
  logic        sys_setn;
  logic        issue;
  logic        rd;
  logic [1:0]  tag2;
  logic        sel;
  logic [12:0] addr;
  logic [31:0] data;
  logic [1:0]  fwd_en;
  logic [31:0] fwd_data;
  logic        stall;
  logic        wb;
  logic        wb32;
  logic [31:0] wb_data;
  logic        err;
  logic        mgmt_req;
  logic [31:0] mgmt_adr;
  logic        mgmt_rwn;
  logic [1:0]  mgmt_wen;
  logic [31:0] mgmt_txd;
  logic        mgmt_ack;
  logic        mgmt_rxe;
  logic [31:0] mgmt_rxd;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rd;
    logic [1:0]  tag;
    logic        sel;
    logic [12:0] addr;
    logic [31:0] data;
    logic [1:0]  fwd_en;
    logic [31:0] fwd_data;
    logic [31:0] rxd;
    logic [31:0] exp_txd;
    logic [1:0]  exp_wen;
    logic        exp_wb32;
    logic [31:0] exp_wb_data;
  } vec_t;

  vec_t vecs[9];

  mp_sysbus_q #(
    .ADDR_W  (13),
    .DEPTH   (4),
    .TIMEOUT (255)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_setn (sys_setn),
    .issue    (issue),
    .rd       (rd),
    .tag2     (tag2),
    .sel      (sel),
    .addr     (addr),
    .data     (data),
    .fwd_en   (fwd_en),
    .fwd_data (fwd_data),
    .stall    (stall),
    .wb       (wb),
    .wb32     (wb32),
    .wb_data  (wb_data),
    .err      (err),
    .mgmt_req (mgmt_req),
    .mgmt_adr (mgmt_adr),
    .mgmt_rwn (mgmt_rwn),
    .mgmt_wen (mgmt_wen),
    .mgmt_txd (mgmt_txd),
    .mgmt_ack (mgmt_ack),
    .mgmt_rxe (mgmt_rxe),
    .mgmt_rxd (mgmt_rxd)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (mgmt_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic set_cmd(input logic r, input logic [1:0] t, input logic s,
                         input logic [12:0] a, input logic [31:0] d,
                         input logic [1:0] fe, input logic [31:0] fd);
    rd = r; tag2 = t; sel = s; addr = a; data = d; fwd_en = fe; fwd_data = fd;
  endtask

  initial begin
    bit ok;
    int bad;
    logic [31:0] d;

    vecs[0] = '{1'b1, TAG_W, 1'b0, 13'h1A4,  32'h0,         2'b00, 32'h0,         32'hDEADBEEF, 32'h0,         2'b00, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b0, TAG_H, 1'b0, 13'h0A0,  32'h12345678,  2'b01, 32'h0000ABCD,  32'h0,        32'hABCD0000,  2'b10, 1'b0, 32'h0};
    vecs[2] = '{1'b0, TAG_W, 1'b0, 13'h1FFF, 32'h11112222,  2'b10, 32'hCAFE0000,  32'h0,        32'hCAFE2222,  2'b11, 1'b0, 32'h0};
    vecs[3] = '{1'b0, TAG_L, 1'b1, 13'h0000, 32'h89AB4567,  2'b00, 32'h0,         32'h0,        32'h000089AB,  2'b01, 1'b0, 32'h0};
    vecs[4] = '{1'b1, TAG_H, 1'b0, 13'h0F0,  32'h0,         2'b00, 32'h0,         32'h5555AAAA, 32'h0,         2'b00, 1'b0, 32'h55555555};
    vecs[5] = '{1'b1, TAG_L, 1'b0, 13'h123,  32'h0,         2'b00, 32'h0,         32'h13579BDF, 32'h0,         2'b00, 1'b0, 32'h13579BDF};
    vecs[6] = '{1'b0, TAG_W, 1'b0, 13'h555,  32'h0,         2'b11, 32'hA5A5A5A5,  32'h0,        32'hA5A5A5A5,  2'b11, 1'b0, 32'h0};
    vecs[7] = '{1'b0, TAG_L, 1'b0, 13'h0AA,  32'hFFFF0000,  2'b01, 32'h0000BEEF,  32'h0,        32'h0000BEEF,  2'b01, 1'b0, 32'h0};
    vecs[8] = '{1'b0, TAG_H, 1'b1, 13'h007,  32'h98765432,  2'b00, 32'h0,         32'h0,        32'h98760000,  2'b10, 1'b0, 32'h0};

    sys_setn = 1'b1; issue = 1'b0;
    set_cmd(1'b0, TAG_W, 1'b0, 13'h0, 32'h0, 2'b00, 32'h0);
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = 32'h0;
    repeat (3) tick();
    sys_setn = 1'b0;
    tick();
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb", wb, 1'b0);
    chk("rst_wb32", wb32, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req", mgmt_req, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);

    // Table of single ops against a zero-wait slave.
    for (int i = 0; i < 9; i++) begin
      set_cmd(vecs[i].rd, vecs[i].tag, vecs[i].sel, vecs[i].addr, vecs[i].data,
              vecs[i].fwd_en, vecs[i].fwd_data);
      issue = 1'b1;
      tick();
      issue = 1'b0;
      chk($sformatf("v%0d_req", i), mgmt_req, 1'b1);
      chk($sformatf("v%0d_adr", i), mgmt_adr, {19'h0, vecs[i].addr});
      chk($sformatf("v%0d_rwn", i), mgmt_rwn, vecs[i].rd);
      chk($sformatf("v%0d_wen", i), mgmt_wen, vecs[i].exp_wen);
      if (!vecs[i].rd) chk($sformatf("v%0d_txd", i), mgmt_txd, vecs[i].exp_txd);
      chk($sformatf("v%0d_stall_t1", i), stall, vecs[i].rd);
      mgmt_ack = 1'b1;
      tick();
      mgmt_ack = 1'b0;
      if (vecs[i].rd) begin
        mgmt_rxe = 1'b1; mgmt_rxd = vecs[i].rxd;
        chk($sformatf("v%0d_stall_t2", i), stall, 1'b1);
        chk($sformatf("v%0d_wb_early", i), wb, 1'b0);
        tick();
        mgmt_rxe = 1'b0;
        chk($sformatf("v%0d_wb", i), wb, 1'b1);
        chk($sformatf("v%0d_wb32", i), wb32, vecs[i].exp_wb32);
        chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_wb_data);
        chk($sformatf("v%0d_stall_t3", i), stall, 1'b0);
        chk($sformatf("v%0d_err", i), err, 1'b0);
        tick();
        chk($sformatf("v%0d_wb_pulse", i), wb, 1'b0);
      end else begin
        chk($sformatf("v%0d_req_one", i), mgmt_req, 1'b0);
        chk($sformatf("v%0d_no_wb", i), wb, 1'b0);
        tick();
      end
      tick();
      tick();
    end

    // Fill the queue with ack held low; the fifth write waits on stall.
    for (int i = 0; i < 4; i++) begin
      d = 32'hF000_0000 | i;
      set_cmd(1'b0, TAG_W, 1'b0, 13'h100 + 13'(i), d, 2'b00, 32'h0);
      exp_q.push_back(d);
      issue = 1'b1;
      tick();
      chk($sformatf("fill%0d_stall", i), stall, (i == 3));
    end
    set_cmd(1'b0, TAG_W, 1'b0, 13'h104, 32'hF000_0004, 2'b00, 32'h0);
    bad = 0;
    repeat (3) begin
      if (!stall || !mgmt_req) bad++;
      tick();
    end
    chk("full_stall_held", bad, 0);
    chk("full_head_txd", mgmt_txd, exp_q.pop_front());
    mgmt_ack = 1'b1;
    tick();
    mgmt_ack = 1'b0;
    chk("full_stall_done", stall, 1'b1);
    tick();
    chk("full_stall_release", stall, 1'b0);
    exp_q.push_back(32'hF000_0004);
    tick();
    issue = 1'b0;
    chk("full_refill_stall", stall, 1'b1);
    for (int n = 0; n < 8 && exp_q.size() > 0; n++) begin
      wait_req(10, ok);
      chk($sformatf("drain%0d_req_seen", n), ok, 1'b1);
      if (!ok) break;
      chk($sformatf("drain%0d_txd", n), mgmt_txd, exp_q.pop_front());
      mgmt_ack = 1'b1;
      tick();
      mgmt_ack = 1'b0;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) tick();
    chk("drain_stall", stall, 1'b0);
    chk("drain_req", mgmt_req, 1'b0);

    // Read with no ack: abort on the 255th cycle after REQ entry.
    set_cmd(1'b1, TAG_W, 1'b0, 13'h002, 32'h0, 2'b00, 32'h0);
    issue = 1'b1;
    tick();
    issue = 1'b0;
    chk("tmo_req", mgmt_req, 1'b1);
    bad = 0;
    for (int n = 1; n <= 254; n++) begin
      tick();
      if (err || wb || !mgmt_req) bad++;
    end
    chk("tmo_quiet", bad, 0);
    tick();
    chk("tmo_err", err, 1'b1);
    chk("tmo_wb", wb, 1'b1);
    chk("tmo_wb32", wb32, 1'b1);
    chk("tmo_wb_data", wb_data, 32'h0);
    chk("tmo_stall", stall, 1'b0);
    tick();
    chk("tmo_err_pulse", err, 1'b0);
    chk("tmo_wb_pulse", wb, 1'b0);
    set_cmd(1'b0, TAG_L, 1'b0, 13'h003, 32'h0000_7777, 2'b00, 32'h0);
    issue = 1'b1;
    tick();
    issue = 1'b0;
    chk("tmo_next_req", mgmt_req, 1'b1);
    chk("tmo_next_txd", mgmt_txd, 32'h0000_7777);
    mgmt_ack = 1'b1;
    tick();
    mgmt_ack = 1'b0;
    repeat (2) tick();

    // Write then read queued: the read waits for the write's ack.
    set_cmd(1'b0, TAG_W, 1'b0, 13'h010, 32'h0BADF00D, 2'b00, 32'h0);
    issue = 1'b1;
    tick();
    set_cmd(1'b1, TAG_W, 1'b0, 13'h020, 32'h0, 2'b00, 32'h0);
    tick();
    issue = 1'b0;
    chk("ord_stall", stall, 1'b1);
    bad = 0;
    repeat (10) begin
      if (!mgmt_req || mgmt_rwn || mgmt_adr != 32'h10 || mgmt_txd != 32'h0BADF00D) bad++;
      tick();
    end
    chk("ord_write_first", bad, 0);
    mgmt_ack = 1'b1;
    tick();
    mgmt_ack = 1'b0;
    chk("ord_gap", mgmt_req, 1'b0);
    wait_req(5, ok);
    chk("ord_rd_req_seen", ok, 1'b1);
    chk("ord_rd_rwn", mgmt_rwn, 1'b1);
    chk("ord_rd_adr", mgmt_adr, 32'h20);
    mgmt_ack = 1'b1;
    tick();
    mgmt_ack = 1'b0;
    mgmt_rxe = 1'b1; mgmt_rxd = 32'h600DCAFE;
    tick();
    mgmt_rxe = 1'b0;
    chk("ord_wb", wb, 1'b1);
    chk("ord_wb_data", wb_data, 32'h600DCAFE);
    chk("ord_stall_end", stall, 1'b0);
    repeat (2) tick();

    // Reset while waiting for read data; late rxe must be ignored.
    set_cmd(1'b1, TAG_H, 1'b0, 13'h030, 32'h0, 2'b00, 32'h0);
    issue = 1'b1;
    tick();
    issue = 1'b0;
    chk("rw_req", mgmt_req, 1'b1);
    mgmt_ack = 1'b1;
    tick();
    mgmt_ack = 1'b0;
    chk("rw_stall_wait", stall, 1'b1);
    sys_setn = 1'b1;
    tick();
    sys_setn = 1'b0;
    chk("rw_stall_rst", stall, 1'b0);
    chk("rw_wb_data_rst", wb_data, 32'h0);
    chk("rw_req_rst", mgmt_req, 1'b0);
    mgmt_rxe = 1'b1; mgmt_rxd = 32'hFFFF_FFFF;
    tick();
    mgmt_rxe = 1'b0;
    bad = 0;
    repeat (5) begin
      if (wb || mgmt_req || stall || err) bad++;
      tick();
    end
    chk("rw_quiet", bad, 0);
    set_cmd(1'b0, TAG_W, 1'b0, 13'h040, 32'h13572468, 2'b00, 32'h0);
    issue = 1'b1;
    tick();
    issue = 1'b0;
    chk("rw_next_req", mgmt_req, 1'b1);
    chk("rw_next_rwn", mgmt_rwn, 1'b0);
    chk("rw_next_adr", mgmt_adr, 32'h40);
    chk("rw_next_txd", mgmt_txd, 32'h13572468);
    mgmt_ack = 1'b1;
    tick();
    mgmt_ack = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
